// File: rtl/operand_reg_bank.sv
// Bank of NUM_REGS operand registers loaded from the switch input, in sequential or direct mode.
// Tracks which registers were loaded this round so the ALU control can wait for all operands.
module operand_reg_bank #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 2,
   parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_pulse,
   input  logic                       load_mode,
   input  logic [SEL_W-1:0]           load_sel,
   input  logic                       clear,
   input  logic [DATA_W-1:0]          sw_input,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic [SEL_W-1:0]           wr_ptr,
   output logic [NUM_REGS-1:0]        loaded_mask,
   output logic                       all_valid,
   output logic                       load_ack
);

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StFull
   } state_e;

   localparam logic [SEL_W-1:0]    LastIdx = SEL_W'(NUM_REGS - 1);
   localparam logic [NUM_REGS-1:0] OneBit  = NUM_REGS'(1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [SEL_W-1:0]    ptr_q, ptr_d, ptr_inc;
   logic [NUM_REGS-1:0] mask_q, mask_d;
   logic [NUM_REGS-1:0] ptr_bit, sel_bit;
   logic                ack_q, ack_d;
   logic                we;
   logic [SEL_W-1:0]    widx;
   logic                sel_ok;

   // Indices at or above NUM_REGS exist only when NUM_REGS is not a power of two.
   assign sel_ok  = (32'(load_sel) < NUM_REGS);
   assign ptr_inc = (ptr_q == LastIdx) ? '0 : ptr_q + SEL_W'(1);
   assign ptr_bit = OneBit << ptr_q;
   assign sel_bit = OneBit << load_sel;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      ptr_d   = ptr_q;
      we      = 1'b0;
      widx    = ptr_q;
      ack_d   = 1'b0;
      if (clear) begin
         state_d = StIdle;
         mask_d  = '0;
         ptr_d   = '0;
      end else if (load_pulse && !load_mode) begin
         we    = 1'b1;
         ack_d = 1'b1;
         ptr_d = ptr_inc;
         if (state_q == StFull) begin
            // A sequential write into a full bank opens a new round.
            mask_d  = ptr_bit;
            state_d = StCollect;
         end else begin
            mask_d  = mask_q | ptr_bit;
            state_d = (&mask_d) ? StFull : StCollect;
         end
      end else if (load_pulse && sel_ok) begin
         we     = 1'b1;
         widx   = load_sel;
         ack_d  = 1'b1;
         mask_d = mask_q | sel_bit;
         if (state_q != StFull) begin
            state_d = (&mask_d) ? StFull : StCollect;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         mask_q  <= '0;
         ptr_q   <= '0;
         ack_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (clear) begin
               regs_q[i] <= '0;
            end else if (we && (widx == SEL_W'(i))) begin
               regs_q[i] <= sw_input;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign wr_ptr      = ptr_q;
   assign loaded_mask = mask_q;
   assign all_valid   = (state_q == StFull);
   assign load_ack    = ack_q;

endmodule

// File: tb/tb_operand_reg_bank.sv
// Scoreboard bench: three bank sizes (2, 4, 3 registers) share one stimulus stream and are
// checked every cycle against a round-based reference model.
module tb_operand_reg_bank;

   typedef struct packed {
      logic [31:0] regs;
      logic [1:0]  ptr;
      logic [3:0]  mask;
      logic        av;
      logic        ack;
   } snap_t;

   typedef snap_t [2:0] trio_t;

   logic        clk;
   logic        rst;
   logic        load_pulse;
   logic        load_mode;
   logic [1:0]  sel;
   logic        clear;
   logic [7:0]  sw_input;

   logic [15:0] rf0;
   logic [31:0] rf1;
   logic [23:0] rf2;
   logic        wp0;
   logic [1:0]  wp1, wp2;
   logic [1:0]  m0;
   logic [3:0]  m1;
   logic [2:0]  m2;
   logic        av0, av1, av2;
   logic        ack0, ack1, ack2;

   int vectors = 0;
   int miscompares = 0;

   trio_t sb[$];

   // Reference model: per bank, register contents, next sequential slot and loaded flags.
   logic [7:0] mregs [3][4];
   bit         mload [3][4];
   int         mptr  [3];
   bit         mack  [3];

   operand_reg_bank #(.DATA_W(8), .NUM_REGS(2)) u_dut0 (
      .clk(clk), .rst(rst), .load_pulse(load_pulse), .load_mode(load_mode),
      .load_sel(sel[0:0]), .clear(clear), .sw_input(sw_input), .regs_flat(rf0),
      .wr_ptr(wp0), .loaded_mask(m0), .all_valid(av0), .load_ack(ack0)
   );

   operand_reg_bank #(.DATA_W(8), .NUM_REGS(4)) u_dut1 (
      .clk(clk), .rst(rst), .load_pulse(load_pulse), .load_mode(load_mode),
      .load_sel(sel), .clear(clear), .sw_input(sw_input), .regs_flat(rf1),
      .wr_ptr(wp1), .loaded_mask(m1), .all_valid(av1), .load_ack(ack1)
   );

   operand_reg_bank #(.DATA_W(8), .NUM_REGS(3)) u_dut2 (
      .clk(clk), .rst(rst), .load_pulse(load_pulse), .load_mode(load_mode),
      .load_sel(sel), .clear(clear), .sw_input(sw_input), .regs_flat(rf2),
      .wr_ptr(wp2), .loaded_mask(m2), .all_valid(av2), .load_ack(ack2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int nr(int k);
      return (k == 0) ? 2 : (k == 1) ? 4 : 3;
   endfunction

   function automatic bit all_loaded(int k);
      for (int i = 0; i < nr(k); i++) begin
         if (!mload[k][i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 4; i++) begin
            mregs[k][i] = 8'h00;
            mload[k][i] = 1'b0;
         end
         mptr[k] = 0;
         mack[k] = 1'b0;
      end
   endfunction

   function automatic void model_step(int k, bit c, bit lp, bit md, int s, logic [7:0] d);
      int tgt;
      mack[k] = 1'b0;
      if (c) begin
         for (int i = 0; i < 4; i++) begin
            mregs[k][i] = 8'h00;
            mload[k][i] = 1'b0;
         end
         mptr[k] = 0;
      end else if (lp && !md) begin
         if (all_loaded(k)) begin
            for (int i = 0; i < 4; i++) mload[k][i] = 1'b0;
         end
         mregs[k][mptr[k]] = d;
         mload[k][mptr[k]] = 1'b1;
         mptr[k] = (mptr[k] + 1) % nr(k);
         mack[k] = 1'b1;
      end else if (lp && md) begin
         tgt = (k == 0) ? (s % 2) : s;
         if (tgt < nr(k)) begin
            mregs[k][tgt] = d;
            mload[k][tgt] = 1'b1;
            mack[k] = 1'b1;
         end
      end
   endfunction

   function automatic snap_t model_snap(int k);
      snap_t s;
      s = '0;
      for (int i = 0; i < nr(k); i++) begin
         s.regs[8*i +: 8] = mregs[k][i];
         s.mask[i] = mload[k][i];
      end
      s.ptr = 2'(mptr[k]);
      s.av  = all_loaded(k);
      s.ack = mack[k];
      return s;
   endfunction

   function automatic snap_t dut_snap(int k);
      snap_t s;
      s = '0;
      if (k == 0) begin
         s.regs = {16'h0, rf0}; s.ptr = {1'b0, wp0}; s.mask = {2'b0, m0};
         s.av = av0; s.ack = ack0;
      end else if (k == 1) begin
         s.regs = rf1; s.ptr = wp1; s.mask = m1; s.av = av1; s.ack = ack1;
      end else begin
         s.regs = {8'h0, rf2}; s.ptr = wp2; s.mask = {1'b0, m2}; s.av = av2; s.ack = ack2;
      end
      return s;
   endfunction

   function automatic void cmp(string name, int k, snap_t e, snap_t a);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s bank%0d @%0t: got regs=%h ptr=%0d mask=%b av=%b ack=%b, want regs=%h ptr=%0d mask=%b av=%b ack=%b",
                  name, k, $time, a.regs, a.ptr, a.mask, a.av, a.ack,
                  e.regs, e.ptr, e.mask, e.av, e.ack);
      end
   endfunction

   function automatic void check_val(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
      end
   endfunction

   // Drive one cycle of stimulus and queue the expected post-edge state of every bank.
   task automatic cycle(input bit r, input bit c, input bit lp, input bit md, input int s,
                        input logic [7:0] d);
      trio_t t;
      @(negedge clk);
      rst        = r;
      clear      = c;
      load_pulse = lp;
      load_mode  = md;
      sel        = 2'(s);
      sw_input   = d;
      if (r) model_reset();
      for (int k = 0; k < 3; k++) begin
         if (!r) model_step(k, c, lp, md, s, d);
         t[k] = model_snap(k);
      end
      sb.push_back(t);
   endtask

   initial begin : monitor
      trio_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) cmp("cycle", k, e[k], dut_snap(k));
         end
      end
   end

   initial begin : driver
      rst = 1'b1; clear = 1'b0; load_pulse = 1'b0; load_mode = 1'b0; sel = 2'd0;
      sw_input = 8'h00;
      model_reset();
      cycle(1, 0, 0, 0, 0, 8'h00);
      cycle(1, 0, 0, 0, 0, 8'h00);
      cycle(0, 0, 0, 0, 0, 8'h00);

      // Sequential fill, then new round from full.
      cycle(0, 0, 1, 0, 0, 8'h03);
      cycle(0, 0, 1, 0, 0, 8'h0C);
      @(posedge clk); #2;
      check_val("fill_regs", {16'h0, rf0}, 32'h0000_0C03);
      check_val("fill_valid", {31'h0, av0}, 32'h1);
      cycle(0, 0, 1, 0, 0, 8'h55);
      @(posedge clk); #2;
      check_val("wrap_regs", {16'h0, rf0}, 32'h0000_0C55);

      // Direct mode: repeated index, then index 3 (invalid for the 3-register bank).
      cycle(0, 1, 0, 0, 0, 8'h00);
      cycle(0, 0, 1, 1, 2, 8'hA5);
      cycle(0, 0, 1, 1, 2, 8'h5A);
      cycle(0, 0, 1, 1, 3, 8'h77);
      @(posedge clk); #2;
      check_val("direct_reg2", {24'h0, rf1[23:16]}, 32'h5A);
      check_val("invalid_ack", {31'h0, ack2}, 32'h0);

      // Clear beats a simultaneous load.
      cycle(0, 1, 1, 0, 0, 8'hFF);
      cycle(0, 0, 0, 0, 0, 8'h00);

      // Asynchronous reset between edges with a partial round.
      cycle(0, 0, 1, 0, 0, 8'h11);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) cmp("async_rst", k, model_snap(k), dut_snap(k));
      cycle(1, 0, 1, 0, 0, 8'h99);
      cycle(1, 0, 0, 0, 0, 8'h00);
      cycle(0, 0, 0, 0, 0, 8'h00);
      cycle(0, 0, 1, 0, 0, 8'h21);

      // Back-to-back sequential pulses.
      cycle(0, 1, 0, 0, 0, 8'h00);
      cycle(0, 0, 1, 0, 0, 8'h11);
      cycle(0, 0, 1, 0, 0, 8'h22);
      cycle(0, 0, 1, 0, 0, 8'h33);
      cycle(0, 0, 1, 0, 0, 8'h44);
      @(posedge clk); #2;
      check_val("b2b_regs", rf1, 32'h4433_2211);
      check_val("b2b_valid", {31'h0, av1}, 32'h1);

      // Randomised traffic.
      for (int n = 0; n < 600; n++) begin
         cycle(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               8'($urandom_range(0, 255)));
      end
      cycle(0, 0, 0, 0, 0, 8'h00);
      @(posedge clk); #3;

      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/operand_reg_bank.md
Name: operand_reg_bank

Overview:
Parametrised successor to the two-operand A/B register updater in the ALU datapath. It holds NUM_REGS operand registers of DATA_W bits, loaded from the switch input under strobe control. There are two load modes: sequential auto-increment, which fills A, B, ... in order, and direct addressed. Completion tracking (loaded_mask, all_valid) lets the ALU control wait until every operand has been entered before computing.

Parameters:
DATA_W, 8, operand width in bits (>=1)
NUM_REGS, 2, number of operand registers (>=2)
SEL_W, $clog2(NUM_REGS), derived pointer/select width; not overridden

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-high
load_pulse  input  1  single-cycle load strobe (from the button edge detector)
load_mode  input  1  0 = sequential, 1 = direct
load_sel  input  SEL_W  target register index in direct mode
clear  input  1  synchronous clear of the bank
sw_input  input  DATA_W  data to load
regs_flat  output  NUM_REGS*DATA_W  register i at bits [i*DATA_W +: DATA_W]; reg0 = A, reg1 = B
wr_ptr  output  SEL_W  next register for sequential mode
loaded_mask  output  NUM_REGS  bit i set once reg i has been loaded in the current round
all_valid  output  1  high when loaded_mask is all ones
load_ack  output  1  one-cycle pulse, registered, the cycle after an accepted write

Behaviour:
- Reset (async, rst=1):
  - all registers = 0, wr_ptr = 0, loaded_mask = 0, all_valid = 0, load_ack = 0.
  - FSM goes to IDLE.
  - Outputs hold these values for as long as rst is high.
- FSM states:
  - IDLE: mask = 0.
  - COLLECT: mask non-zero and not full.
  - FULL: mask all ones.
  - all_valid = (state == FULL); registered, never combinational from inputs.
- Priority per rising edge: rst > clear > load_pulse.
- clear=1: registers, wr_ptr and mask go to 0 and state goes to IDLE. A simultaneous load_pulse is dropped and load_ack = 0.
- Sequential load (load_pulse=1, load_mode=0):
  - reg[wr_ptr] <= sw_input; wr_ptr <= wr_ptr+1, wrapping to 0 after NUM_REGS-1.
  - IDLE/COLLECT: set mask bit wr_ptr; go to FULL if the mask becomes all ones, else COLLECT.
  - FULL: start a new round. Mask <= only bit wr_ptr (wr_ptr is 0 after a full wrap); state COLLECT. Other registers keep their values.
- Direct load (load_pulse=1, load_mode=1):
  - Valid index (load_sel < NUM_REGS): reg[load_sel] <= sw_input and mask bit load_sel is set. wr_ptr is unchanged.
  - From FULL, a valid direct load stays in FULL and does not restart the round. From IDLE/COLLECT, the state follows the mask.
  - Invalid index (load_sel >= NUM_REGS, only possible when NUM_REGS is not a power of 2): no write, no state change, load_ack = 0.
- Latency:
  - A write is visible on regs_flat one cycle after the strobed edge.
  - loaded_mask, all_valid and wr_ptr update in the same cycle as the write.
  - load_ack is high for exactly the cycle following each accepted write, so it coincides with the new data being visible.
- Pulses on consecutive cycles: each is accepted independently and load_ack stays high for consecutive cycles. There is no rate limit.
- load_pulse held high: treated as one load per cycle. Strobe conditioning is upstream.
- sw_input is sampled only on an accepted edge. Values between loads have no effect.
- Width rule: sw_input is stored verbatim, with no sign extension or truncation (widths match by construction).
- Reset asserted mid-round: everything returns to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset/sequential fill (DATA_W=8, NUM_REGS=2): after reset all outputs are 0. Load 0x03 then 0x0C in sequential mode → A=0x03, B=0x0C, mask 01 then 11, all_valid=1 after the second write, wr_ptr 1 then 0, one load_ack per write.
- Wrap/new round: from FULL (A=0x03, B=0x0C), sequential load 0x55 → A=0x55, B=0x0C unchanged, mask=01, all_valid=0, wr_ptr=1.
- Direct mode (NUM_REGS=4): load_sel=2 with 0xA5 → reg2=0xA5, mask=0100, wr_ptr=0. Then load_sel=2 with 0x5A → reg2=0x5A and the mask is unchanged. NUM_REGS=3: load_sel=3 → no write, load_ack=0.
- Clear vs load same cycle: clear=1 and load_pulse=1 with 0xFF → all registers 0, mask 0, all_valid 0, load_ack 0.
- Async reset mid-operation: assert rst between clock edges while mask=01 → outputs go to 0 before the next edge, and stay there until release plus a new load.
- Back-to-back pulses: 4 consecutive-cycle sequential loads 0x11, 0x22, 0x33, 0x44 (NUM_REGS=4) → regs_flat = 0x44332211, load_ack high for 4 consecutive cycles, all_valid=1.
